// File: rtl/cla_pkg.sv
// Shared widths, result payload and 4-bit lookahead helper for the pipelined CLA subtractor.
package cla_pkg;

  localparam int unsigned CLA_WIDTH = 32;
  localparam int unsigned CLA_SPLIT = 16;
  localparam int unsigned BLK_W     = 16;

  typedef struct packed {
    logic [CLA_WIDTH-1:0] diff;
    logic                 borrow;
    logic                 ovf;
  } cla_result_t;

  // Carries c[0..4] of a 4-bit slice from generate/propagate and carry-in, fully expanded.
  function automatic logic [4:0] lookahead4(input logic [3:0] g, input logic [3:0] p,
                                            input logic c0);
    logic [4:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

endpackage

// File: rtl/cla_block16.sv
// 16-bit combinational two-level carry-lookahead adder: four 4-bit groups under a group lookahead.
module cla_block16
  import cla_pkg::*;
(
  input  logic [BLK_W-1:0] a,
  input  logic [BLK_W-1:0] b,
  input  logic             cin,
  output logic [BLK_W-1:0] sum,
  output logic             cout
);

  logic [BLK_W-1:0] g;
  logic [BLK_W-1:0] p;
  logic [BLK_W-1:0] c;
  logic [3:0]       gg;
  logic [3:0]       gp;
  logic [4:0]       gc;
  logic [4:0]       lk;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    gp = '0;
    c  = '0;
    lk = '0;
    // Group generate/propagate, then carries into each group, then carries within groups
    for (int j = 0; j < 4; j++) begin
      lk    = lookahead4(g[4*j +: 4], p[4*j +: 4], 1'b0);
      gg[j] = lk[4];
      gp[j] = &p[4*j +: 4];
    end
    gc = lookahead4(gg, gp, cin);
    for (int j = 0; j < 4; j++) begin
      lk           = lookahead4(g[4*j +: 4], p[4*j +: 4], gc[j]);
      c[4*j +: 4]  = lk[3:0];
    end
    sum  = p ^ c;
    cout = gc[4];
  end

endmodule

// File: rtl/cla_sub_pipe32.sv
// Two-stage pipelined 32-bit subtractor (a + ~b + 1) with valid/ready on both sides.
// Optional signed-overflow output enabled by defining CLA_SUB_OVF_EN.
module cla_sub_pipe32
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = CLA_WIDTH,
  parameter int unsigned SPLIT = CLA_SPLIT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow
`ifdef CLA_SUB_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int unsigned HI_W = WIDTH - SPLIT;

  logic [SPLIT-1:0] nb_lo;
  logic [SPLIT-1:0] lo_sum;
  logic             lo_cout;
  logic [HI_W-1:0]  hi_sum;
  logic             hi_cout;

  logic             s1_valid_q, s1_valid_d;
  logic [SPLIT-1:0] s1_lo_q, s1_lo_d;
  logic             s1_c_q, s1_c_d;
  logic [HI_W-1:0]  s1_a_q, s1_a_d;
  logic [HI_W-1:0]  s1_nb_q, s1_nb_d;

  logic             s2_valid_q, s2_valid_d;
  cla_result_t      s2_res_q, s2_res_d;

  logic             s2_adv;
  logic             in_fire;

  assign nb_lo = ~in_b[SPLIT-1:0];

  cla_block16 u_lo (
    .a    (in_a[SPLIT-1:0]),
    .b    (nb_lo),
    .cin  (1'b1),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  cla_block16 u_hi (
    .a    (s1_a_q),
    .b    (s1_nb_q),
    .cin  (s1_c_q),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  // Handshake and next-state for both stages; S1 drains into S2 whenever S2 can take it.
  always_comb begin
    s2_adv     = !s2_valid_q || out_ready;
    in_ready   = !s1_valid_q || s2_adv;
    in_fire    = in_valid && in_ready;

    s1_valid_d = s1_valid_q;
    s1_lo_d    = s1_lo_q;
    s1_c_d     = s1_c_q;
    s1_a_d     = s1_a_q;
    s1_nb_d    = s1_nb_q;
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_lo_d    = lo_sum;
      s1_c_d     = lo_cout;
      s1_a_d     = in_a[WIDTH-1:SPLIT];
      s1_nb_d    = ~in_b[WIDTH-1:SPLIT];
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_res_d.diff   = {hi_sum, s1_lo_q};
        s2_res_d.borrow = ~hi_cout;
`ifdef CLA_SUB_OVF_EN
        // Operand signs agree in a + ~b and the result sign differs from a
        s2_res_d.ovf    = (s1_a_q[HI_W-1] == s1_nb_q[HI_W-1]) &&
                          (hi_sum[HI_W-1] != s1_a_q[HI_W-1]);
`else
        s2_res_d.ovf    = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_lo_q    <= '0;
      s1_c_q     <= 1'b0;
      s1_a_q     <= '0;
      s1_nb_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_lo_q    <= s1_lo_d;
      s1_c_q     <= s1_c_d;
      s1_a_q     <= s1_a_d;
      s1_nb_q    <= s1_nb_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_diff   = s2_res_q.diff;
  assign out_borrow = s2_res_q.borrow;
`ifdef CLA_SUB_OVF_EN
  assign out_ovf    = s2_res_q.ovf;
`endif

endmodule

// File: doc/cla_sub_pipe32.md
CLA_SUB_PIPE32 -- requirements
Module: cla_sub_pipe32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; only 32 is supported.
REQ-002 SHALL have parameter SPLIT, default 16, bit position of the stage boundary.
REQ-003 SHALL have port clock, input, 1, sole clock; all flops rise-edge.
REQ-004 SHALL have port reset, input, 1; one clock, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, in_a/in_b valid this cycle.
REQ-006 SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-007 SHALL have port in_a, input, 32, minuend, unsigned.
REQ-008 SHALL have port in_b, input, 32, subtrahend, unsigned.
REQ-009 SHALL have port out_valid, output, 1, out_diff/out_borrow valid.
REQ-010 SHALL have port out_ready, input, 1, consumer takes result this cycle.
REQ-011 SHALL have port out_diff, output, 32, (in_a - in_b) mod 2^32.
REQ-012 SHALL have port out_borrow, output, 1, high when in_a < in_b unsigned.

Function
REQ-013 SHALL compute diff = a + ~b + 1 via carry-lookahead; borrow = NOT carry-out of bit 31.
REQ-014 SHALL accept a transfer when in_valid && in_ready, and emit one when out_valid && out_ready.
REQ-015 SHALL use two register stages: S1 holds low 16 diff bits, carry into bit 16, and upper 16 bits of a and ~b; S2 holds full result.
REQ-016 SHALL present a result exactly 2 cycles after acceptance when out_ready stays high.
REQ-017 SHALL sustain one accept and one emit per cycle with out_ready held high.
REQ-018 SHALL advance S2 when !s2_valid || out_ready; S1 advances into S2 under the same condition.
REQ-019 SHALL drive in_ready = !s1_valid || s2_advance, combinationally; no in_valid-to-in_ready path.
REQ-020 SHALL hold out_diff/out_borrow stable while out_valid && !out_ready.
REQ-021 SHALL never drop, duplicate or reorder transfers; capacity is exactly 2 results.
REQ-022 SHALL with both stages full and out_ready low deassert in_ready; if out_ready rises the same cycle an input arrives, accept it.
REQ-023 SHALL ignore in_a/in_b when no transfer occurs.
REQ-024 SHALL give a == b -> diff 0, borrow 0; 0 - 1 -> 0xFFFFFFFF, borrow 1 (wrap-around).

Reset
REQ-025 SHALL on reset low clear s1_valid, s2_valid; out_valid = 0, out_diff = 0, out_borrow = 0, in_ready = 1 during reset.
REQ-026 SHALL discard all in-flight operands on reset assertion mid-operation; no result emerges after release.
REQ-027 SHALL accept input on the first rising clock edge after reset deasserts.

Configuration
REQ-028 SHALL with CLA_SUB_OVF_EN defined add output out_ovf, 1, two's-complement signed overflow (a[31] != b[31] && diff[31] != a[31]), pipelined aligned with out_diff, reset 0.
REQ-029 SHALL without CLA_SUB_OVF_EN have no out_ovf port and no overflow logic; all other behaviour identical.

Structure
REQ-030 SHALL place WIDTH, SPLIT defaults and a result struct typedef (diff, borrow, ovf) in shared package cla_pkg.
REQ-031 SHALL instantiate sub-module cla_block16 (16-bit combinational CLA: a, b, cin -> sum, cout) twice, once per stage.

Verification
REQ-032 SHALL cover: a=100, b=58, out_ready=1 -> 2 cycles later out_diff=42, out_borrow=0.
REQ-033 SHALL cover: a=0, b=1 -> out_diff=0xFFFFFFFF, out_borrow=1; a=0x12345678, b=0x12345678 -> 0, borrow 0.
REQ-034 SHALL cover: a=0x0001_0000, b=0x0000_0001 (borrow across stage boundary) -> out_diff=0x0000_FFFF, borrow 0.
REQ-035 SHALL cover: out_ready low, 3 back-to-back inputs -> 2 accepted, in_ready=0 on third; raise out_ready -> results in order, third accepted same cycle.
REQ-036 SHALL cover: reset pulled low with both stages valid -> out_valid=0 immediately, no result after release.
REQ-037 SHALL cover (CLA_SUB_OVF_EN): a=0x80000000, b=1 -> out_diff=0x7FFFFFFF, out_ovf=1; 10000 random a,b vs. reference a-b, zero mismatches.
